// File: rtl/imem_loader.sv
// Program loader for a core's instruction memory. It packs a byte stream (MSB first) into
// 32-bit words, writes them to consecutive addresses, then holds the core in reset for a while and releases it.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_start,
   input  logic [7:0]  word_count,
   input  logic        abort,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        instwen,
   output logic [31:0] addwrite,
   output logic [31:0] instrdatain,
   output logic        core_reset,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      HOLD  = 3'd3,
      RUN   = 3'd4
   } state_t;

   localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

   state_t      state_r, state_s;
   logic [7:0]  remaining_r, remaining_s;
   logic [31:0] addr_r, addr_s;
   logic [1:0]  idx_r, idx_s;
   logic [31:0] word_r, word_s;
   logic [7:0]  hold_cnt_r, hold_cnt_s;
   logic        write_fire_s;

   logic        instwen_r;
   logic [31:0] addwrite_r;
   logic [31:0] instrdatain_r;
   logic        core_reset_r;
   logic        busy_r;
   logic        done_r;

   assign byte_ready  = (state_r == LOAD);
   assign instwen     = instwen_r;
   assign addwrite    = addwrite_r;
   assign instrdatain = instrdatain_r;
   assign core_reset  = core_reset_r;
   assign busy        = busy_r;
   assign done        = done_r;

   // Next-state and datapath decode for the load sequencer.
   always_comb begin
      state_s      = state_r;
      remaining_s  = remaining_r;
      addr_s       = addr_r;
      idx_s        = idx_r;
      word_s       = word_r;
      hold_cnt_s   = hold_cnt_r;
      write_fire_s = 1'b0;
      case (state_r)
         IDLE, RUN: begin
            if (load_start) begin
               if (word_count == 8'd0) begin
                  state_s    = HOLD;
                  hold_cnt_s = HOLD_INIT;
               end else begin
                  state_s     = LOAD;
                  remaining_s = word_count;
                  addr_s      = BASE_ADDR;
                  idx_s       = 2'd0;
               end
            end else begin
               state_s = state_r;
            end
         end
         LOAD: begin
            if (abort) begin
               state_s = IDLE;
               idx_s   = 2'd0;
            end else if (byte_valid) begin
               word_s = {word_r[23:0], byte_in};
               if (idx_r == 2'd3) begin
                  idx_s   = 2'd0;
                  state_s = WRITE;
               end else begin
                  idx_s = idx_r + 2'd1;
               end
            end else begin
               state_s = LOAD;
            end
         end
         WRITE: begin
            // The write strobe is registered from this cycle so a same-cycle abort can still suppress it.
            if (abort) begin
               state_s = IDLE;
            end else begin
               write_fire_s = 1'b1;
               addr_s       = addr_r + 32'd4;
               remaining_s  = remaining_r - 8'd1;
               if (remaining_r == 8'd1) begin
                  state_s    = HOLD;
                  hold_cnt_s = HOLD_INIT;
               end else begin
                  state_s = LOAD;
               end
            end
         end
         HOLD: begin
            if (hold_cnt_r == 8'd0) begin
               state_s = RUN;
            end else begin
               hold_cnt_s = hold_cnt_r - 8'd1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered output update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         remaining_r   <= 8'd0;
         addr_r        <= BASE_ADDR;
         idx_r         <= 2'd0;
         word_r        <= 32'd0;
         hold_cnt_r    <= 8'd0;
         instwen_r     <= 1'b0;
         addwrite_r    <= BASE_ADDR;
         instrdatain_r <= 32'd0;
         core_reset_r  <= 1'b1;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r     <= state_s;
         remaining_r <= remaining_s;
         addr_r      <= addr_s;
         idx_r       <= idx_s;
         word_r      <= word_s;
         hold_cnt_r  <= hold_cnt_s;
         instwen_r   <= write_fire_s;
         if (write_fire_s) begin
            addwrite_r    <= addr_r;
            instrdatain_r <= word_r;
         end else begin
            addwrite_r    <= addwrite_r;
            instrdatain_r <= instrdatain_r;
         end
         core_reset_r <= (state_s != RUN);
         busy_r       <= (state_s == LOAD) || (state_s == WRITE) || (state_s == HOLD);
         done_r       <= (state_s == RUN);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the basic/reload flows plus
// hand-written sequences for backpressure, zero count, abort and asynchronous reset.
module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic        load_start;
   logic [7:0]  word_count;
   logic        abort;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        instwen;
   logic [31:0] addwrite;
   logic [31:0] instrdatain;
   logic        core_reset;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   logic [63:0] wr_q[$];

   imem_loader dut (
      .clk(clk), .reset(reset), .load_start(load_start), .word_count(word_count),
      .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .instwen(instwen), .addwrite(addwrite), .instrdatain(instrdatain),
      .core_reset(core_reset), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every write strobe seen mid-cycle.
   always @(negedge clk) begin
      if (instwen === 1'b1) wr_q.push_back({addwrite, instrdatain});
   end

   typedef struct {
      logic        ls;
      logic [7:0]  wc;
      logic        ab;
      logic [7:0]  b;
      logic        bv;
      logic [4:0]  ctl;   // {byte_ready, instwen, core_reset, busy, done}
      logic [31:0] aw;
      logic [31:0] id;
   } vec_t;

   vec_t vecs[25];

   function automatic vec_t mk(input logic ls, input logic [7:0] wc, input logic ab,
                               input logic [7:0] b, input logic bv, input logic [4:0] ctl,
                               input logic [31:0] aw, input logic [31:0] id);
      vec_t v;
      v.ls = ls; v.wc = wc; v.ab = ab; v.b = b; v.bv = bv;
      v.ctl = ctl; v.aw = aw; v.id = id;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [4:0] ctl, input logic [31:0] aw,
                        input logic [31:0] id);
      logic [4:0] act;
      act = {byte_ready, instwen, core_reset, busy, done};
      checks++;
      if (act !== ctl || addwrite !== aw || instrdatain !== id) begin
         errors++;
         $display("FAIL %s: got ctl=%b aw=%h id=%h, expected ctl=%b aw=%h id=%h",
                  name, act, addwrite, instrdatain, ctl, aw, id);
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      load_start = 1'b0; word_count = 8'd0; abort = 1'b0; byte_in = 8'd0; byte_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic start(input logic [7:0] wc);
      load_start = 1'b1;
      word_count = wc;
      tick();
      load_start = 1'b0;
      word_count = 8'd0;
   endtask

   // Wait gap idle cycles, then offer b until the loader takes it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit taken;
      taken = 1'b0;
      for (int g = 0; g < gap; g++) begin
         byte_valid = 1'b0;
         tick();
      end
      byte_in    = b;
      byte_valid = 1'b1;
      for (int k = 0; k < 20 && !taken; k++) begin
         taken = byte_ready;
         tick();
      end
      byte_valid = 1'b0;
      if (!taken) begin
         checks++;
         errors++;
         $display("FAIL send_byte_timeout: byte %h not accepted, expected acceptance within 20 cycles", b);
      end
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 40 && done !== 1'b1; i++) tick();
      check_val(name, {63'd0, done}, 64'd1);
   endtask

   initial begin
      logic [7:0] bytes8[8];
      bytes8 = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};

      // Basic two-word load, reload of one word from RUN, then a zero-count restart from RUN.
      vecs[0]  = mk(1, 8'd2, 0, 8'h00, 0, 5'b10110, 32'h0, 32'h0);
      vecs[1]  = mk(0, 8'd0, 0, 8'h20, 1, 5'b10110, 32'h0, 32'h0);
      vecs[2]  = mk(0, 8'd0, 0, 8'h02, 1, 5'b10110, 32'h0, 32'h0);
      vecs[3]  = mk(0, 8'd0, 0, 8'h00, 1, 5'b10110, 32'h0, 32'h0);
      vecs[4]  = mk(0, 8'd0, 0, 8'h05, 1, 5'b00110, 32'h0, 32'h0);
      vecs[5]  = mk(0, 8'd0, 0, 8'h20, 1, 5'b11110, 32'h0, 32'h20020005);
      vecs[6]  = mk(0, 8'd0, 0, 8'h20, 1, 5'b10110, 32'h0, 32'h20020005);
      vecs[7]  = mk(0, 8'd0, 0, 8'h03, 1, 5'b10110, 32'h0, 32'h20020005);
      vecs[8]  = mk(0, 8'd0, 0, 8'h00, 1, 5'b10110, 32'h0, 32'h20020005);
      vecs[9]  = mk(0, 8'd0, 0, 8'h0C, 1, 5'b00110, 32'h0, 32'h20020005);
      vecs[10] = mk(0, 8'd0, 0, 8'h00, 0, 5'b01110, 32'h4, 32'h2003000C);
      vecs[11] = mk(0, 8'd0, 0, 8'h00, 0, 5'b00110, 32'h4, 32'h2003000C);
      vecs[12] = mk(0, 8'd0, 0, 8'h00, 0, 5'b00001, 32'h4, 32'h2003000C);
      vecs[13] = mk(0, 8'd0, 1, 8'h00, 0, 5'b00001, 32'h4, 32'h2003000C);
      vecs[14] = mk(1, 8'd1, 0, 8'h00, 0, 5'b10110, 32'h4, 32'h2003000C);
      vecs[15] = mk(0, 8'd0, 0, 8'hAC, 1, 5'b10110, 32'h4, 32'h2003000C);
      vecs[16] = mk(0, 8'd0, 0, 8'h02, 1, 5'b10110, 32'h4, 32'h2003000C);
      vecs[17] = mk(0, 8'd0, 0, 8'h00, 1, 5'b10110, 32'h4, 32'h2003000C);
      vecs[18] = mk(0, 8'd0, 0, 8'h54, 1, 5'b00110, 32'h4, 32'h2003000C);
      vecs[19] = mk(0, 8'd0, 0, 8'h00, 0, 5'b01110, 32'h0, 32'hAC020054);
      vecs[20] = mk(0, 8'd0, 0, 8'h00, 0, 5'b00110, 32'h0, 32'hAC020054);
      vecs[21] = mk(0, 8'd0, 0, 8'h00, 0, 5'b00001, 32'h0, 32'hAC020054);
      vecs[22] = mk(1, 8'd0, 0, 8'h00, 0, 5'b00110, 32'h0, 32'hAC020054);
      vecs[23] = mk(0, 8'd0, 1, 8'h00, 0, 5'b00110, 32'h0, 32'hAC020054);
      vecs[24] = mk(0, 8'd0, 0, 8'h00, 0, 5'b00001, 32'h0, 32'hAC020054);

      do_reset();
      check("reset_values", 5'b00100, 32'h0, 32'h0);

      for (int i = 0; i < 25; i++) begin
         load_start = vecs[i].ls;
         word_count = vecs[i].wc;
         abort      = vecs[i].ab;
         byte_in    = vecs[i].b;
         byte_valid = vecs[i].bv;
         tick();
         check($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].aw, vecs[i].id);
      end
      load_start = 1'b0; abort = 1'b0; byte_valid = 1'b0;

      // Backpressure: 3 idle cycles before every byte, plus an ignored load_start mid-word.
      do_reset();
      wr_q.delete();
      start(8'd2);
      for (int i = 0; i < 8; i++) begin
         send_byte(bytes8[i], 3);
         if (i == 1) begin
            load_start = 1'b1;
            word_count = 8'd5;
            tick();
            load_start = 1'b0;
            word_count = 8'd0;
         end
      end
      wait_done("bp_done");
      check_val("bp_write_count", 64'(wr_q.size()), 64'd2);
      if (wr_q.size() >= 2) begin
         check_val("bp_write0", wr_q[0], {32'h0, 32'h20020005});
         check_val("bp_write1", wr_q[1], {32'h4, 32'h2003000C});
      end

      // Asynchronous reset between edges during a reload from RUN.
      wr_q.delete();
      start(8'd1);
      send_byte(8'hAC, 0);
      send_byte(8'h02, 0);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_values", 5'b00100, 32'h0, 32'h0);
      tick();
      reset = 1'b0;
      byte_in = 8'h00; byte_valid = 1'b1;
      repeat (4) tick();
      byte_valid = 1'b0;
      check("after_reset_idle", 5'b00100, 32'h0, 32'h0);
      check_val("after_reset_no_write", 64'(wr_q.size()), 64'd0);

      // Zero word count from IDLE; abort during HOLD is ignored.
      wr_q.delete();
      start(8'd0);
      check("zero_hold1", 5'b00110, 32'h0, 32'h0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("zero_hold2", 5'b00110, 32'h0, 32'h0);
      tick();
      check("zero_run", 5'b00001, 32'h0, 32'h0);
      check_val("zero_no_write", 64'(wr_q.size()), 64'd0);

      // Abort after 2 bytes, then abort while in WRITE, then a clean load.
      do_reset();
      wr_q.delete();
      start(8'd2);
      send_byte(8'h20, 0);
      send_byte(8'h02, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_load_idle", 5'b00100, 32'h0, 32'h0);
      start(8'd1);
      send_byte(8'hAC, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h54, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_write_idle", 5'b00100, 32'h0, 32'h0);
      tick();
      check_val("abort_no_write", 64'(wr_q.size()), 64'd0);
      start(8'd1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 1);
      wait_done("abort_reload_done");
      check_val("abort_reload_count", 64'(wr_q.size()), 64'd1);
      if (wr_q.size() >= 1) check_val("abort_reload_write", wr_q[0], {32'h0, 32'h11223344});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
